// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel word handshake in, registered serial stream out
interface piso_tx_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic dout;
  logic frame;
  logic par_flag;
  logic done;
  modport master (output din, din_valid, input din_ready, dout, frame, par_flag, done);
  modport slave (input din, din_valid, output din_ready, dout, frame, par_flag, done);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with optional parity and gapless back-to-back words
module piso_tx #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clock,
  input logic reset,
  piso_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic par;
  logic take;
  // done marks the final serial cycle, which is exactly when a reload may happen
  assign bus.din_ready = state == IDLE || bus.done;
  assign take = bus.din_valid && bus.din_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      bus.dout <= 1'b0;
      bus.frame <= 1'b0;
      bus.par_flag <= 1'b0;
      bus.done <= 1'b0;
    end else if (take) begin
      state <= SHIFT;
      cnt <= '0;
      sh <= MSB_FIRST ? bus.din << 1 : bus.din >> 1;
      par <= ^bus.din ^ PARITY_ODD;
      bus.dout <= MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
      bus.frame <= 1'b1;
      bus.par_flag <= 1'b0;
      bus.done <= 1'b0;
    end else if (state == SHIFT && cnt != LAST) begin
      cnt <= cnt + 1'b1;
      sh <= MSB_FIRST ? sh << 1 : sh >> 1;
      bus.dout <= MSB_FIRST ? sh[WIDTH-1] : sh[0];
      bus.done <= !PARITY_EN && cnt + 1'b1 == LAST;
    end else if (state == SHIFT && PARITY_EN) begin
      state <= PARITY;
      bus.dout <= par;
      bus.frame <= 1'b0;
      bus.par_flag <= 1'b1;
      bus.done <= 1'b1;
    end else begin
      state <= IDLE;
      bus.dout <= 1'b0;
      bus.frame <= 1'b0;
      bus.par_flag <= 1'b0;
      bus.done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: four parameter variants driven in lockstep and checked against a symbol-stream model
module tb_piso_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [3:0] din = 4'b0;
  logic [3:0] outs [4];
  logic rdys [4];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [3:0] sym [4][5];
  int len [4];
  int pos [4];
  logic [7:0] mh [4];
  always #5 clk = ~clk;
  for (genvar i = 0; i < 4; i++) begin : g_cfg
    piso_tx_if #(.WIDTH(4)) bus ();
    assign bus.din = din;
    assign bus.din_valid = valid;
    assign outs[i] = {bus.dout, bus.frame, bus.par_flag, bus.done};
    assign rdys[i] = bus.din_ready;
    piso_tx #(.WIDTH(4), .MSB_FIRST(i != 3), .PARITY_EN(i == 1 || i == 2), .PARITY_ODD(i == 2)) dut (
      .clock(clk),
      .reset(reset),
      .bus(bus)
    );
  end
  // a word becomes its list of serial symbols {dout, frame, par_flag, done}
  task automatic load(input int c, input logic [3:0] d);
    bit msb, pe, odd;
    msb = c != 3;
    pe = c == 1 || c == 2;
    odd = c == 2;
    for (int k = 0; k < 4; k++) sym[c][k] = {msb ? d[3-k] : d[k], 1'b1, 1'b0, k == 3 && !pe};
    if (pe) sym[c][4] = {^d ^ odd, 1'b0, 1'b1, 1'b1};
    len[c] = pe ? 5 : 4;
    pos[c] = 0;
  endtask
  task automatic update(input logic v, input logic [3:0] d, input logic r);
    for (int c = 0; c < 4; c++) begin
      bit busy, rd;
      busy = pos[c] < len[c];
      rd = !busy || sym[c][pos[c]][0];
      if (busy) pos[c]++;
      if (r) begin
        pos[c] = 0;
        len[c] = 0;
      end else if (v && rd) load(c, d);
    end
  endtask
  task automatic compare();
    for (int c = 0; c < 4; c++) begin
      logic [3:0] e;
      logic er;
      e = pos[c] < len[c] ? sym[c][pos[c]] : 4'b0;
      er = pos[c] >= len[c] || sym[c][pos[c]][0];
      mh[c] = {mh[c][6:0], e[3]};
      if (chk_en) begin
        n_cmp++;
        if (outs[c] !== e) begin
          n_bad++;
          $display("FAIL outputs cfg%0d t=%0t: {dout,frame,par_flag,done} got %b want %b", c, $time, outs[c], e);
        end
        n_cmp++;
        if (rdys[c] !== er) begin
          n_bad++;
          $display("FAIL din_ready cfg%0d t=%0t: got %b want %b", c, $time, rdys[c], er);
        end
      end
    end
  endtask
  task automatic chk_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask
  task automatic step(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    compare();
    valid = v;
    din = d;
    reset = r;
    @(posedge clk);
    update(v, d, r);
  endtask
  task automatic word(input logic [3:0] d);
    step(1'b1, d, 1'b0);
    repeat (6) step(1'b0, 4'b0, 1'b0);
  endtask
  initial begin
    for (int c = 0; c < 4; c++) begin
      len[c] = 0;
      pos[c] = 0;
      mh[c] = '0;
    end
    step(1'b0, 4'bx, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 4'b0, 1'b1);
    word(4'b1011);
    chk_lit("single word msb", {4'b0, mh[0][5:2]}, 8'b1011);
    chk_lit("single word even parity", {3'b0, mh[1][5:1]}, 8'b10111);
    chk_lit("single word odd parity", {3'b0, mh[2][5:1]}, 8'b10110);
    chk_lit("single word lsb", {4'b0, mh[3][5:2]}, 8'b1101);
    word(4'b0111);
    chk_lit("parity even 0111", {3'b0, mh[1][5:1]}, 8'b01111);
    chk_lit("parity odd 0111", {3'b0, mh[2][5:1]}, 8'b01110);
    word(4'b0001);
    chk_lit("lsb first 0001", {4'b0, mh[3][5:2]}, 8'b1000);
    step(1'b1, 4'hC, 1'b0);
    repeat (3) step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    repeat (4) step(1'b0, 4'b0, 1'b0);
    chk_lit("back to back C then 3", mh[0], 8'b11000011);
    repeat (3) step(1'b0, 4'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    repeat (2) step(1'b0, 4'b0, 1'b0);
    step(1'b0, 4'b0, 1'b1);
    step(1'b0, 4'b0, 1'b0);
    chk_lit("reset mid-word cfg0", {4'b0, outs[0]}, 8'b0);
    chk_lit("ready after reset", {7'b0, rdys[0]}, 8'b1);
    word(4'b1001);
    chk_lit("clean word after reset", {4'b0, mh[0][5:2]}, 8'b1001);
    for (int n = 0; n < 600; n++) begin
      logic v;
      v = $urandom_range(0, 3) != 0;
      step(v, v ? 4'($urandom) : 4'bx, $urandom_range(0, 49) == 0);
    end
    step(1'b0, 4'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter that sits directly upstream of the 4-bit serial-in parallel-out shift register and drives its serial data input.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first by default.
- Emits an optional parity bit after the data bits.
- Supports back-to-back words with no idle bubble, so a downstream SIPO sees a continuous stream.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
- PARITY_EN, 0, 1 = append one parity bit after each word.
- PARITY_ODD, 0, 0 = even parity (data bits plus parity bit have an even count of 1s); 1 = odd parity.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word for transfer.
- din_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data, registered.
- frame  output  1  high while dout carries a data bit.
- par_flag  output  1  high while dout carries the parity bit.
- done  output  1  one-cycle pulse on the last serial cycle of a word (data or parity).

Behaviour:
- Reset is synchronous and active-high on clock. On reset:
  - state = IDLE;
  - dout = 0, frame = 0, par_flag = 0, done = 0;
  - bit counter = 0, shift register = 0;
  - din_ready = 1 in the cycle after reset deasserts.
- Transfer occurs at a rising edge where din_valid && din_ready. din is captured at that edge.
- States:
  - IDLE: dout = 0, frame = 0. On transfer, go to SHIFT.
  - SHIFT: WIDTH cycles, one data bit per cycle, frame = 1. After the last bit, go to PARITY if PARITY_EN, else to IDLE, or reload on a new transfer.
  - PARITY: one cycle, dout = parity bit, par_flag = 1, frame = 0. Then go to IDLE, or reload on a new transfer.
- Latency: the first data bit appears on dout in the cycle immediately after the accepting edge (one-clock latency). Bit k (k = 0..WIDTH-1 in shift order) is on dout in cycle k+1.
- din_ready is combinational:
  - 1 in IDLE;
  - 1 on the final serial cycle of a word (last data bit if PARITY_EN = 0, parity cycle otherwise);
  - 0 otherwise.
- Back-to-back: a transfer on the final serial cycle loads the new word, and its first bit follows on the next cycle with no gap. frame stays high continuously when PARITY_EN = 0.
- done = 1 exactly on the final serial cycle of each word, independent of whether a new word is accepted.
- Parity is the XOR of the captured word, inverted when PARITY_ODD = 1. It is computed at capture and held.
- din and din_valid are ignored while din_ready = 0. A word is never lost or duplicated.
- Bit counter width is clog2(WIDTH). It wraps to 0 on reload and is never compared beyond WIDTH-1.
- Reset mid-word aborts the word:
  - dout = 0 and frame = 0 on the next cycle;
  - no done pulse for the aborted word.
- reset has priority over a simultaneous transfer; that word is dropped.
- X-safety: dout is never X after reset, including while din is X in IDLE.

Test Plan:
- Single word, defaults:
  - Stimulus: reset 2 cycles, then din = 4'b1011, din_valid = 1 for one cycle.
  - Response: dout = 1,0,1,1 on the next 4 cycles; frame high for those 4 cycles; done on the 4th; then dout = 0, din_ready = 1.
  - Chained to the sipo: qout = 4'b1011 after the 4th bit is sampled.
- Back-to-back:
  - Stimulus: din_valid held high with words 4'hC then 4'h3.
  - Response: dout = 1,1,0,0,0,0,1,1 with no gap; frame high for 8 consecutive cycles; din_ready high only on cycles 4 and 8; done pulses on cycles 4 and 8.
- Parity (PARITY_EN = 1):
  - Even (PARITY_ODD = 0), din = 4'b0111: response is 0,1,1,1 then parity 1 with par_flag = 1 and frame = 0.
  - Odd (PARITY_ODD = 1), same word: parity bit = 0.
- LSB first (MSB_FIRST = 0):
  - Stimulus: din = 4'b0001.
  - Response: dout = 1,0,0,0.
- Handshake stall:
  - Stimulus: din_valid asserted mid-word with din = 4'hF, din changed to 4'h5 before din_ready rises.
  - Response: the word accepted and shifted is 4'h5 (the value present when din_ready = 1); the earlier value is not transmitted.
- Reset mid-operation:
  - Stimulus: assert reset after bit 2 of 4'b1111.
  - Response: next cycle dout = 0, frame = 0, done = 0; after release, din_ready = 1 and a new word transmits cleanly.
